// File: rtl/rv32i_pkg.sv
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared RV32I types and constants for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FAULT_NONE         = 2'b00,
        FAULT_MISALIGNED   = 2'b01,
        FAULT_OUT_OF_RANGE = 2'b10
    } fetch_fault_e;

    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        fetch_fault_e    fault;
    } if_id_t;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_reg.sv
// ============================================================================
// Module      : fetch_pc_reg
// Description : Program counter with redirect / increment / hold next-PC mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_reg
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_advance,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;

    // Redirect wins over advance; 32-bit add wraps naturally at the top of memory.
    always_comb begin
        w_pc_next = r_pc;
        if (i_redirect) begin
            w_pc_next = i_target;
        end else if (i_advance) begin
            w_pc_next = r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : RV32I fetch stage - PC, IMEM addressing and IF/ID slot register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instruction,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [1:0]  id_fault,
    output logic [31:0] fetch_count
);

    logic [XLEN-1:0] w_pc;
    logic            w_slot_free;
    logic            w_transfer;
    logic            w_load;
    fetch_fault_e    w_fault;
    if_id_t          w_slot_next;

    if_id_t          r_slot;
    logic            r_valid;
    logic [31:0]     r_count;

    assign w_slot_free = !r_valid || id_ready;
    assign w_transfer  = r_valid && id_ready;
    assign w_load      = !redirect_valid && w_slot_free && fetch_en;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .i_redirect (redirect_valid),
        .i_target   (redirect_target),
        .i_advance  (w_load),
        .o_pc       (w_pc)
    );

    assign imem_addr = {2'b00, w_pc[31:2]};

    // Misalignment is reported ahead of range so a bad low-order PC is never masked.
    always_comb begin
        w_fault = FAULT_NONE;
        if (w_pc[1:0] != 2'b00) begin
            w_fault = FAULT_MISALIGNED;
        end else if (w_pc[31:2] >= 30'(IMEM_WORDS)) begin
            w_fault = FAULT_OUT_OF_RANGE;
        end
    end

    always_comb begin
        w_slot_next.instruction = (w_fault == FAULT_NONE) ? imem_instruction : NOP_INSTR;
        w_slot_next.pc          = w_pc;
        w_slot_next.pc_plus4    = w_pc + 32'd4;
        w_slot_next.fault       = w_fault;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid             <= 1'b0;
            r_slot.instruction  <= NOP_INSTR;
            r_slot.pc           <= '0;
            r_slot.pc_plus4     <= '0;
            r_slot.fault        <= FAULT_NONE;
            r_count             <= '0;
        end else begin
            if (w_transfer) begin
                r_count <= r_count + 32'd1;
            end
            // A redirect flushes the slot even when decode is taking it this cycle.
            if (redirect_valid) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
                r_slot  <= w_slot_next;
            end else if (w_slot_free) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign id_valid       = r_valid;
    assign id_instruction = r_slot.instruction;
    assign id_pc          = r_slot.pc;
    assign id_pc_plus4    = r_slot.pc_plus4;
    assign id_fault       = r_slot.fault;
    assign fetch_count    = r_count;

endmodule

`default_nettype wire
